spi_reg_bridge: RTL

//  SPI slave (mode 0, MSB first) that turns host SPI frames into single-cycle register-file accesses.

---
 rtl/spi_reg_bridge.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that converts host frames into single-cycle register-file
// read/write strobes, with auto-incrementing burst addressing.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [5:0] address,
    output logic       write_en,
    output logic [7:0] wr_data,
    output logic       read_en,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        RD_ISSUE,
        RD_LOAD,
        DATA
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_d1_q;
    logic                   cs_lvl_q;
    logic                   mosi_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   cs_rise_q;
    logic                   cs_fall_q;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       rw_q;
    logic [5:0] address_q;
    logic       write_en_q;
    logic [7:0] wr_data_q;
    logic       read_en_q;
    logic       busy_q;
    logic       ferr_q;

    logic [7:0] rx_next;
    logic       active;
    logic       byte_done;

    // Synchronisers are left unreset so they keep tracking the real pins through reset.
    always_ff @(posedge clock) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_d1_q   <= sclk_sync_q[SYNC_STAGES-1];
        cs_lvl_q    <= cs_sync_q[SYNC_STAGES-1];
        mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end

    // Edge events are registered so they act one clock after detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cs_rise_q <= 1'b0;
            cs_fall_q <= 1'b0;
        end else begin
            rise_q    <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_d1_q;
            fall_q    <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_d1_q;
            cs_rise_q <= cs_sync_q[SYNC_STAGES-1] & ~cs_lvl_q;
            cs_fall_q <= ~cs_sync_q[SYNC_STAGES-1] & cs_lvl_q;
        end
    end

    assign rx_next   = {rx_q, mosi_q};
    assign active    = (state_q == CMD) || (state_q == RD_ISSUE) ||
                       (state_q == RD_LOAD) || (state_q == DATA);
    assign byte_done = rise_q && (bit_cnt_q == 3'd7) &&
                       ((state_q == CMD) || (state_q == DATA));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WAIT_CS;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 8'd0;
            rw_q       <= 1'b0;
            address_q  <= 6'd0;
            write_en_q <= 1'b0;
            wr_data_q  <= 8'd0;
            read_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b1;
            // Write strobe goes out with the old address; step it the cycle after.
            if (write_en_q) address_q <= address_q + 6'd1;
            if (active && rise_q) begin
                rx_q      <= rx_next[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (active && fall_q && (bit_cnt_q != 3'd0)) tx_q <= {tx_q[6:0], 1'b0};
            case (state_q)
                WAIT_CS: begin
                    if (cs_lvl_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    busy_q <= 1'b0;
                    if (cs_fall_q) begin
                        state_q   <= CMD;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= 8'd0;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        rw_q      <= rx_next[7];
                        address_q <= rx_next[5:0];
                        if (rx_next[7]) begin
                            state_q <= DATA;
                        end else begin
                            state_q   <= RD_ISSUE;
                            read_en_q <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: state_q <= RD_LOAD;
                RD_LOAD: begin
                    tx_q    <= rd_data;
                    state_q <= DATA;
                end
                DATA: begin
                    if (byte_done) begin
                        if (rw_q) begin
                            wr_data_q  <= rx_next;
                            write_en_q <= 1'b1;
                        end else begin
                            address_q <= address_q + 6'd1;
                            read_en_q <= 1'b1;
                            state_q   <= RD_ISSUE;
                        end
                    end
                end
                default: state_q <= WAIT_CS;
            endcase
            // A byte completing together with cs_n rising still gets its strobe.
            if (cs_rise_q && active) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                ferr_q  <= (bit_cnt_q != 3'd0) && !byte_done;
            end
        end
    end

    assign spi_miso  = ~spi_cs_n & tx_q[7];
    assign address   = address_q;
    assign write_en  = write_en_q;
    assign wr_data   = wr_data_q;
    assign read_en   = read_en_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule
